mips_debug_unit: RTL

- UART-side controller sitting directly upstream of the MIPS core.
- Consumes received bytes and loads program words into instruction memory.
- Gates the core's clock-enable for run and single-step, and controls core reset.
- After run or step, streams PC and the 32-register file back over UART TX, little-endian.

---
 rtl/mips_debug_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_debug_unit.sv
// UART command front-end for the MIPS core: program load into instruction memory,
// run/single-step clock gating, core reset, and PC/register-file dump over TX.
module mips_debug_unit #(
  parameter int unsigned IMEM_ADDR_W = 8,
  parameter logic [7:0]  ABORT_BYTE  = 8'h58
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [7:0]             RxData,
  input  logic                   RxValid,
  output logic [7:0]             TxData,
  output logic                   TxStart,
  input  logic                   TxBusy,
  output logic                   ImemWrEn,
  output logic [IMEM_ADDR_W-1:0] ImemWrAddr,
  output logic [31:0]            ImemWrData,
  output logic                   CpuEnable,
  output logic                   CpuReset,
  output logic [4:0]             DbgRegAddr,
  input  logic [31:0]            DbgRegData,
  input  logic [31:0]            PCResult,
  input  logic                   Halted,
  output logic                   Busy
);

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_DONE, RUN, STEP, DUMP_LOAD, DUMP_SEND, DUMP_WAIT
  } state_t;

  state_t                 state, state_n;
  logic [IMEM_ADDR_W-1:0] load_addr, load_addr_n;
  logic [8:0]             words_left, words_left_n;
  logic [1:0]             byte_cnt, byte_cnt_n;
  logic [23:0]            byte_buf, byte_buf_n;
  logic [31:0]            word, word_n;
  logic [5:0]             dump_idx, dump_idx_n;
  logic [1:0]             byte_sel, byte_sel_n;
  logic                   skip, skip_n;

  logic [7:0]             tx_data_n;
  logic                   tx_start_n, wr_en_n, cpu_en_n, cpu_rst_n;
  logic [IMEM_ADDR_W-1:0] wr_addr_n;
  logic [31:0]            wr_data_n;
  logic [4:0]             dbg_addr_n;

  always_comb begin
    state_n      = state;
    load_addr_n  = load_addr;
    words_left_n = words_left;
    byte_cnt_n   = byte_cnt;
    byte_buf_n   = byte_buf;
    word_n       = word;
    dump_idx_n   = dump_idx;
    byte_sel_n   = byte_sel;
    skip_n       = skip;
    tx_data_n    = TxData;
    tx_start_n   = 1'b0;
    wr_en_n      = 1'b0;
    wr_addr_n    = ImemWrAddr;
    wr_data_n    = ImemWrData;
    cpu_en_n     = 1'b0;
    cpu_rst_n    = 1'b0;
    dbg_addr_n   = DbgRegAddr;

    unique case (state)
      IDLE: begin
        if (RxValid) begin
          case (RxData)
            8'h4C: state_n = LD_CNT;
            8'h43: begin
              if (Halted) begin
                state_n = DUMP_LOAD;
              end else begin
                state_n  = RUN;
                cpu_en_n = 1'b1;
              end
            end
            8'h53: begin
              state_n  = STEP;
              cpu_en_n = 1'b1;
            end
            8'h52:   cpu_rst_n = 1'b1;
            default: ;
          endcase
        end
      end

      LD_CNT: begin
        if (RxValid) begin
          words_left_n = (RxData == 8'h00) ? 9'd256 : {1'b0, RxData};
          load_addr_n  = '0;
          byte_cnt_n   = '0;
          state_n      = LD_BYTE;
        end
      end

      // Bytes shift in from the top so the first byte lands in bits [7:0].
      LD_BYTE: begin
        if (RxValid) begin
          if (byte_cnt == 2'd3) begin
            wr_en_n      = 1'b1;
            wr_addr_n    = load_addr;
            wr_data_n    = {RxData, byte_buf};
            load_addr_n  = load_addr + 1'b1;
            words_left_n = words_left - 9'd1;
            byte_cnt_n   = '0;
            if (words_left == 9'd1) state_n = LD_DONE;
          end else begin
            byte_buf_n = {RxData, byte_buf[23:8]};
            byte_cnt_n = byte_cnt + 2'd1;
          end
        end
      end

      LD_DONE: begin
        cpu_rst_n = 1'b1;
        state_n   = IDLE;
      end

      RUN: begin
        if (Halted || (RxValid && RxData == ABORT_BYTE)) begin
          state_n = DUMP_LOAD;
        end else begin
          cpu_en_n = 1'b1;
        end
      end

      STEP: state_n = DUMP_LOAD;

      // dump_idx is 0 on entry; word 0 is the PC, word k is register k-1.
      DUMP_LOAD: begin
        word_n     = (dump_idx == 6'd0) ? PCResult : DbgRegData;
        byte_sel_n = '0;
        state_n    = DUMP_SEND;
      end

      DUMP_SEND: begin
        if (!TxBusy) begin
          tx_data_n  = word[{byte_sel, 3'b000} +: 8];
          tx_start_n = 1'b1;
          skip_n     = 1'b1;
          state_n    = DUMP_WAIT;
        end
      end

      // The first wait cycle is skipped because TxBusy only rises after TxStart.
      DUMP_WAIT: begin
        if (skip) begin
          skip_n = 1'b0;
        end else if (!TxBusy) begin
          if (byte_sel == 2'd3) begin
            if (dump_idx == 6'd32) begin
              dump_idx_n = '0;
              state_n    = IDLE;
            end else begin
              dump_idx_n = dump_idx + 6'd1;
              dbg_addr_n = dump_idx[4:0];
              state_n    = DUMP_LOAD;
            end
          end else begin
            byte_sel_n = byte_sel + 2'd1;
            state_n    = DUMP_SEND;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      load_addr  <= '0;
      words_left <= '0;
      byte_cnt   <= '0;
      byte_buf   <= '0;
      word       <= '0;
      dump_idx   <= '0;
      byte_sel   <= '0;
      skip       <= 1'b0;
      TxData     <= '0;
      TxStart    <= 1'b0;
      ImemWrEn   <= 1'b0;
      ImemWrAddr <= '0;
      ImemWrData <= '0;
      CpuEnable  <= 1'b0;
      CpuReset   <= 1'b1;
      DbgRegAddr <= '0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_n;
      load_addr  <= load_addr_n;
      words_left <= words_left_n;
      byte_cnt   <= byte_cnt_n;
      byte_buf   <= byte_buf_n;
      word       <= word_n;
      dump_idx   <= dump_idx_n;
      byte_sel   <= byte_sel_n;
      skip       <= skip_n;
      TxData     <= tx_data_n;
      TxStart    <= tx_start_n;
      ImemWrEn   <= wr_en_n;
      ImemWrAddr <= wr_addr_n;
      ImemWrData <= wr_data_n;
      CpuEnable  <= cpu_en_n;
      CpuReset   <= cpu_rst_n;
      DbgRegAddr <= dbg_addr_n;
      Busy       <= (state_n != IDLE);
    end
  end

endmodule
